// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer and datapath.
package booth_pkg;

   localparam int unsigned BOOTH_WIDTH  = 16;
   localparam int unsigned BOOTH_CNT_W  = 5;
   localparam int unsigned BOOTH_N_ITER = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LDM,
      ST_LDQ,
      ST_EVAL,
      ST_SHIFT,
      ST_DONE,
      ST_CLR
   } booth_state_t;

endpackage

// File: rtl/booth_seq_ctrl.sv
// Booth multiplier sequencer: steps the datapath through load, evaluate and shift phases.
// Optional feature macro: BOOTH_FAST_SHIFT_EN (shift in EVAL when no add/sub is needed).
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter int unsigned N_ITER = BOOTH_N_ITER
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   input  logic q0,
   input  logic qm1,
   input  logic eqz,
   output logic mcand_rd,
   output logic mplier_rd,
   output logic loadA,
   output logic loadQ,
   output logic loadM,
   output logic clrA,
   output logic clrQ,
   output logic clrff,
   output logic shftA,
   output logic shftQ,
   output logic decr,
   output logic ldcnt,
   output logic addsub,
   output logic busy,
   output logic done
);

   if ((N_ITER < 1) || (N_ITER > (2 ** BOOTH_CNT_W) - 1)) begin : g_n_iter_range
      $error("booth_seq_ctrl: N_ITER must fit the datapath counter and be nonzero");
   end

   booth_state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_rd  = 1'b0;
      mplier_rd = 1'b0;
      loadA     = 1'b0;
      loadQ     = 1'b0;
      loadM     = 1'b0;
      clrA      = 1'b0;
      clrQ      = 1'b0;
      clrff     = 1'b0;
      shftA     = 1'b0;
      shftQ     = 1'b0;
      decr      = 1'b0;
      ldcnt     = 1'b0;
      addsub    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LDM;
         end
         ST_LDM: begin
            busy     = 1'b1;
            mcand_rd = 1'b1;
            loadM    = 1'b1;
            clrA     = 1'b1;
            clrff    = 1'b1;
            state_d  = abort ? ST_CLR : ST_LDQ;
         end
         ST_LDQ: begin
            busy      = 1'b1;
            mplier_rd = 1'b1;
            loadQ     = 1'b1;
            ldcnt     = 1'b1;
            state_d   = abort ? ST_CLR : ST_EVAL;
         end
         ST_EVAL: begin
            busy = 1'b1;
            if (eqz) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
               unique case ({q0, qm1})
                  2'b10: begin
                     loadA  = 1'b1;
                     addsub = 1'b0;
                  end
                  2'b01: begin
                     loadA  = 1'b1;
                     addsub = 1'b1;
                  end
                  default: begin
`ifdef BOOTH_FAST_SHIFT_EN
                     // nothing to add: fold the shift into this cycle and re-evaluate
                     shftA   = 1'b1;
                     shftQ   = 1'b1;
                     decr    = 1'b1;
                     state_d = ST_EVAL;
`endif
                  end
               endcase
            end
            // abort outranks both termination and iteration
            if (abort) state_d = ST_CLR;
         end
         ST_SHIFT: begin
            busy    = 1'b1;
            shftA   = 1'b1;
            shftQ   = 1'b1;
            decr    = 1'b1;
            state_d = abort ? ST_CLR : ST_EVAL;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         ST_CLR: begin
            busy    = 1'b1;
            clrA    = 1'b1;
            clrQ    = 1'b1;
            clrff   = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl driving a behavioural 16-bit Booth datapath.
module tb_booth_seq_ctrl;

   localparam int N = 16;

   logic clk;
   logic rst_n, start, abort;
   logic q0, qm1, eqz;
   logic mcand_rd, mplier_rd, loadA, loadQ, loadM, clrA, clrQ, clrff;
   logic shftA, shftQ, decr, ldcnt, addsub, busy, done;

   logic [15:0] mcand, mplier, data_in;
   logic [15:0] dp_A = '0, dp_Q = '0, dp_M = '0;
   logic        dp_qm1 = 1'b0;
   logic [4:0]  dp_cnt = '0;

   int          mc_cnt = 0, mp_cnt = 0, viol = 0, done_cnt = 0;
   logic [4:0]  dec_n = '0;
   logic [31:0] add_mask = '0, sub_mask = '0;

   int n_chk = 0;
   int n_err = 0;

   logic [14:0] outs;
   assign outs = {mcand_rd, mplier_rd, loadA, loadQ, loadM, clrA, clrQ, clrff,
                  shftA, shftQ, decr, ldcnt, addsub, busy, done};

   booth_seq_ctrl #(.N_ITER(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .q0(q0), .qm1(qm1), .eqz(eqz),
      .mcand_rd(mcand_rd), .mplier_rd(mplier_rd),
      .loadA(loadA), .loadQ(loadQ), .loadM(loadM),
      .clrA(clrA), .clrQ(clrQ), .clrff(clrff),
      .shftA(shftA), .shftQ(shftQ), .decr(decr), .ldcnt(ldcnt),
      .addsub(addsub), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Operand source and datapath
   assign data_in = mcand_rd ? mcand : (mplier_rd ? mplier : 16'h0000);
   assign q0  = dp_Q[0];
   assign qm1 = dp_qm1;
   assign eqz = (dp_cnt == 5'd0);

   always @(posedge clk) begin
      if (loadM) dp_M <= data_in;
      if (loadQ) dp_Q <= data_in;
      if (clrQ)  dp_Q <= '0;
      if (clrA)  dp_A <= '0;
      if (clrff) dp_qm1 <= 1'b0;
      if (loadA) dp_A <= addsub ? dp_A + dp_M : dp_A - dp_M;
      if (shftA && shftQ) {dp_A, dp_Q, dp_qm1} <= {dp_A[15], dp_A, dp_Q};
      if (ldcnt) dp_cnt <= 5'(N);
      else if (decr) dp_cnt <= dp_cnt - 5'd1;
   end

   // Strobe trace recorder
   always @(posedge clk) begin
      if (mcand_rd)  mc_cnt <= mc_cnt + 1;
      if (mplier_rd) mp_cnt <= mp_cnt + 1;
      if (done)      done_cnt <= done_cnt + 1;
      if ((loadA && shftA) || (ldcnt && decr)) viol <= viol + 1;
      if (ldcnt) begin
         dec_n    <= '0;
         add_mask <= '0;
         sub_mask <= '0;
      end else begin
         if (loadA) begin
            if (addsub) add_mask[dec_n] <= 1'b1;
            else        sub_mask[dec_n] <= 1'b1;
         end
         if (decr) dec_n <= dec_n + 5'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Booth recoding of the multiplier: which iterations add and which subtract
   function automatic void ref_ops(input logic [15:0] q, output logic [31:0] am,
                                   output logic [31:0] sm, output int nops);
      logic prev;
      am = '0; sm = '0; nops = 0; prev = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (q[i] && !prev) begin sm[i] = 1'b1; nops++; end
         if (!q[i] && prev) begin am[i] = 1'b1; nops++; end
         prev = q[i];
      end
   endfunction

   task automatic finish_op(input logic [15:0] m, input logic [15:0] q, input bit jitter,
                            input bit hold, input int mc0, input int mp0, input string tag);
      int lat, exp_lat, nops, mi, qi, p;
      logic [31:0] am_e, sm_e;
      ref_ops(q, am_e, sm_e, nops);
      lat = 1;
      while (done !== 1'b1 && lat < 300) begin
         if (jitter) start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      if (!hold) start = 1'b0;
`ifdef BOOTH_FAST_SHIFT_EN
      exp_lat = N + nops + 4;
`else
      exp_lat = 2 * N + 4;
`endif
      mi = int'($signed(m));
      qi = int'($signed(q));
      p  = mi * qi;
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".product"}, {dp_A, dp_Q}, p);
      chk({tag, ".mcand_rd_pulses"}, mc_cnt - mc0, 1);
      chk({tag, ".mplier_rd_pulses"}, mp_cnt - mp0, 1);
      chk({tag, ".add_iters"}, add_mask, am_e);
      chk({tag, ".sub_iters"}, sub_mask, sm_e);
      chk({tag, ".strobe_conflicts"}, viol, 0);
      if (!hold) begin
         @(posedge clk); #1;
         chk({tag, ".idle_after_done"}, {busy, done}, 2'b00);
      end
   endtask

   task automatic run_op(input logic [15:0] m, input logic [15:0] q, input bit jitter,
                         input bit hold, input string tag);
      int mc0, mp0;
      mcand = m; mplier = q;
      mc0 = mc_cnt; mp0 = mp_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      finish_op(m, q, jitter, hold, mc0, mp0, tag);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int mc0, mp0, k, d0;
      logic [15:0] m, q;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mcand = '0; mplier = '0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset.outputs", 32'(outs), 32'h0);
      rst_n = 1'b1;

      run_op(16'd3, 16'd5, 1'b0, 1'b0, "m3q5");
      run_op(16'h7FFF, 16'h8000, 1'b0, 1'b0, "maxneg");
      chk("maxneg.single_sub_at_iter16", sub_mask, 32'h0000_8000);
      chk("maxneg.no_adds", add_mask, 32'h0);
      run_op(16'hFFF9, 16'hFFFD, 1'b0, 1'b0, "neg7neg3");

      // reset during SHIFT
      mcand = 16'd3; mplier = 16'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_shift.eval_sub", {loadA, addsub}, 2'b10);
      @(posedge clk); #1;
      chk("rst_shift.in_shift", {shftA, shftQ, decr, busy}, 4'b1111);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_shift.outputs", 32'(outs), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'd1234, 16'hFF00, 1'b0, 1'b0, "post_rst");

      // abort in iteration-5 EVAL, with start pulses while busy
      d0 = done_cnt;
      mcand = 16'd77; mplier = 16'h5A5A; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      chk("abort.ldq", {mplier_rd, ldcnt}, 2'b11);
      k = 0;
      while (dp_cnt != 5'(N - 4) && k < 100) begin
         start = ~start;
         @(posedge clk); #1;
         k++;
      end
      chk("abort.reached_iter5", {27'h0, dp_cnt}, 32'(N - 4));
      chk("abort.busy_before", busy, 1'b1);
      abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      chk("abort.clr_cycle", 32'(outs), 32'h0000_0382);
      @(posedge clk); #1;
      chk("abort.idle", 32'(outs), 32'h0);
      @(posedge clk); #1;
      chk("abort.no_done", done_cnt - d0, 0);
      run_op(16'hFF80, 16'd300, 1'b0, 1'b0, "post_abort");

      // start held through DONE launches the next operation from IDLE
      run_op(16'd100, 16'd200, 1'b0, 1'b1, "b2b_first");
      mcand = 16'hABCD; mplier = 16'h0123;
      mc0 = mc_cnt; mp0 = mp_cnt;
      @(posedge clk); #1;
      chk("b2b.idle_gap", {busy, done, mcand_rd}, 3'b000);
      @(posedge clk); #1;
      chk("b2b.second_ldm", {busy, mcand_rd}, 2'b11);
      start = 1'b0;
      finish_op(16'hABCD, 16'h0123, 1'b0, 1'b0, mc0, mp0, "b2b_second");

      for (int i = 0; i < 8; i++) begin
         m = 16'($urandom);
         q = 16'($urandom);
         if (m == 16'h8000) m = 16'h8001;
         run_op(m, q, 1'b1, 1'b0, "random");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequencer for the 16-bit radix-2 Booth multiplier datapath. It accepts a start request and steps the datapath through five phases using its load, clear, shift, add/sub, counter and flip-flop strobes. The phases are: operand load, counter load, add/subtract evaluation, arithmetic shift, and termination on counter-zero. It sits between the operand source (which drives the shared `data_in` bus on request) and the datapath, and reports `busy`/`done` to the system.

## Interface
Parameters:
- `N_ITER`, 16, iteration count loaded into the datapath counter; legal range 1..31.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin a multiplication; sampled in IDLE only
- `abort`  in  1  cancel an in-flight operation; sampled in any busy state
- `q0`  in  1  datapath Q[0]
- `qm1`  in  1  datapath Q(-1) flip-flop
- `eqz`  in  1  datapath counter == 0
- `mcand_rd`  out  1  source must drive multiplicand on `data_in` this cycle
- `mplier_rd`  out  1  source must drive multiplier on `data_in` this cycle
- `loadA`, `loadQ`, `loadM`, `clrA`, `clrQ`, `clrff`, `shftA`, `shftQ`, `decr`, `ldcnt`  out  1 each  datapath strobes
- `addsub`  out  1  1 = A+M, 0 = A−M; meaningful only with `loadA`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: product valid in A:Q

## Operation
- States: IDLE, LDM, LDQ, EVAL, SHIFT, DONE, CLR.
- IDLE:
  - All strobes 0.
  - `start`=1 → LDM.
- LDM:
  - `mcand_rd`, `loadM`, `clrA`, `clrff` = 1.
  - → LDQ.
- LDQ:
  - `mplier_rd`, `loadQ`, `ldcnt` = 1; counter loads `N_ITER`.
  - → EVAL.
- EVAL:
  - If `eqz`=1: no strobes → DONE.
  - Else decode {q0,qm1}:
    - 10: `loadA`=1, `addsub`=0 (subtract).
    - 01: `loadA`=1, `addsub`=1 (add).
    - 00/11: no `loadA`.
  - → SHIFT.
- SHIFT:
  - `shftA`, `shftQ`, `decr` = 1 (arithmetic right shift of A:Q:qm1).
  - → EVAL.
- DONE:
  - `done`=1, `busy`=0.
  - → IDLE.
  - A `start` seen here is ignored; it must be held into IDLE to be accepted.
- CLR:
  - `clrA`, `clrQ`, `clrff` = 1.
  - → IDLE, no `done`.
- `busy`=1 in LDM, LDQ, EVAL, SHIFT, CLR.
- `abort` in LDM/LDQ/EVAL/SHIFT → CLR. If `abort` and `eqz` coincide in EVAL, abort wins.
- `start` while busy: ignored.
- Datapath strobes are decoded combinationally from state, {q0,qm1} and `eqz`. `busy` and `done` are decoded from the registered state only.
- Never assert `loadA` together with `shftA`, or `ldcnt` together with `decr`.

## Timing
- Reset (`rst_n`=0 at an edge) → IDLE from any state. After that edge all outputs are 0, `busy`=0, `done`=0. A mid-operation reset abandons the product silently.
- Latency, with `start` sampled at edge 0:
  - LDM is cycle 1, LDQ is cycle 2.
  - Iterations occupy cycles 3..2·N_ITER+2.
  - The terminating EVAL is cycle 2·N_ITER+3.
  - `done` is high in cycle 2·N_ITER+4, i.e. 36 for N_ITER=16.
- Back-to-back: the earliest next start is sampled in the IDLE cycle after DONE.
- The operand source must drive `data_in` combinationally within the cycle `mcand_rd`/`mplier_rd` is high.

## Configuration
- `BOOTH_FAST_SHIFT_EN` defined:
  - In EVAL, with `eqz`=0 and {q0,qm1} ∈ {00,11}, assert `shftA`/`shftQ`/`decr` in the same cycle and stay in EVAL.
  - Latency becomes N_ITER + (number of add/sub iterations) + 4.
- Undefined:
  - Fixed two-cycle iterations as specified above.
  - Fixed latency 2·N_ITER+4.

## Structure
- Shared package `booth_pkg`:
  - State enum `booth_state_t`.
  - `BOOTH_WIDTH`=16.
  - `BOOTH_CNT_W`=5.
  - Default `N_ITER`.
- Single module; no sub-module. State register plus one combinational decode block.

## Test plan
- Reset mid-SHIFT → next cycle: IDLE, all outputs 0, `busy`=0; a later `start` behaves normally.
- M=3, Q=5, N_ITER=16, with the real datapath → `done` at cycle 36, A:Q = 0x0000_000F.
- M=0x7FFF, Q=0x8000 → A:Q = 0xC000_8000. Exactly one subtract occurs, at iteration 16, plus zero adds; verify the `loadA`/`addsub` trace.
- M=−7 (0xFFF9), Q=−3 (0xFFFD) → A:Q = 0x0000_0015. Checked with the macro off (latency 36) and on (latency N_ITER+#ops+4).
- `abort` in iteration 5 EVAL → CLR for one cycle with `clrA`/`clrQ`/`clrff`, then IDLE. No `done` pulse; `start` pulses during busy are ignored.
- `start` held high through DONE → second operation starts in the IDLE cycle after DONE. `mcand_rd`/`mplier_rd` pulse exactly once each per operation.
